// File: rtl/clint_pkg.sv
// Shared constants, access-record type and byte-lane merge helper for the
// multi-hart machine timer / software interrupt unit.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] DIV_OFF      = 16'hBFF0;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [3:0]  ACCESS_LEN   = 4'd8;

  typedef struct packed {
    logic        store;
    logic [63:0] addr;
    logic [3:0]  len;
    logic [63:0] val;
  } MMIOPack;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Data-side MMIO request/response bundle between a requester and the timer unit.
interface clint_timer_if;

  logic [63:0] address_i;
  logic [63:0] indata_i;
  logic        wen_i;
  logic        ren_i;
  logic [7:0]  mask_i;
  logic [63:0] outdata_o;
  logic        valid_o;

  modport master (
    output address_i, indata_i, wen_i, ren_i, mask_i,
    input  outdata_o, valid_o
  );

  modport slave (
    input  address_i, indata_i, wen_i, ren_i, mask_i,
    output outdata_o, valid_o
  );

endinterface

// File: rtl/clint_prescaler.sv
// Programmable divider producing the mtime increment tick: one tick every DIV+1 cycles.
module clint_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_we,
  input  logic [DIV_W-1:0] div_wdata,
  output logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pcnt;

  assign tick = (pcnt == div);

  // A divide write restarts the period so the new rate applies from a clean edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      pcnt <= '0;
    end else if (div_we) begin
      div  <= div_wdata;
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Multi-hart machine timer and software interrupt unit: shared prescaled mtime,
// per-hart mtimecmp/msip, registered interrupt outputs and a one-cycle MMIO port.
module clint_timer
  import clint_pkg::*;
#(
  parameter int          NUM_HARTS = 2,
  parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
  parameter int          DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  clint_timer_if.slave         bus,
  output logic [NUM_HARTS-1:0] time_int_o,
  output logic [NUM_HARTS-1:0] soft_int_o,
  output MMIOPack              cosim_mmio,
  output logic [63:0]          cosim_mtime
);

  logic [63:0]          mtime;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic [NUM_HARTS-1:0] time_hit;
  logic [DIV_W-1:0]     div;
  logic                 tick;

  logic [63:0]          off;
  logic                 in_region;
  logic [11:0]          msip_idx;
  logic [12:0]          cmp_idx;
  logic                 msip_area;
  logic                 cmp_area;
  logic                 div_hit;
  logic                 mtime_hit;
  logic [NUM_HARTS-1:0] msip_hit;
  logic [NUM_HARTS-1:0] cmp_hit;
  logic                 msip_lane_en;
  logic                 msip_lane_bit;
  logic [63:0]          rd_data_p0;

  // Decode: misaligned accesses fall through as unmapped.
  assign off       = bus.address_i - BASE_ADDR;
  assign in_region = (off[63:16] == '0);
  assign msip_idx  = off[13:2];
  assign cmp_idx   = off[15:3] - MTIMECMP_OFF[15:3];
  assign msip_area = in_region && (off[15:14] == MSIP_OFF[15:14]) && (off[1:0] == 2'b00);
  assign cmp_area  = in_region && (off[15:0] >= MTIMECMP_OFF) && (off[15:0] < DIV_OFF)
                     && (off[2:0] == 3'b000);
  assign div_hit   = in_region && (off[15:0] == DIV_OFF);
  assign mtime_hit = in_region && (off[15:0] == MTIME_OFF);

  always_comb begin
    msip_hit = '0;
    cmp_hit  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      msip_hit[h] = msip_area && (msip_idx == 12'(h));
      cmp_hit[h]  = cmp_area && (cmp_idx == 13'(h));
    end
  end

  // Odd harts' MSIP words sit in the upper 32-bit lane of the doubleword.
  assign msip_lane_en  = off[2] ? bus.mask_i[4]    : bus.mask_i[0];
  assign msip_lane_bit = off[2] ? bus.indata_i[32] : bus.indata_i[0];

  always_comb begin
    rd_data_p0 = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_hit[h]) rd_data_p0 = off[2] ? {31'b0, msip[h], 32'b0} : {63'b0, msip[h]};
      if (cmp_hit[h])  rd_data_p0 = mtimecmp[h];
    end
    if (div_hit)   rd_data_p0 = 64'(div);
    if (mtime_hit) rd_data_p0 = mtime;
  end

  clint_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .div_we    (bus.wen_i && div_hit),
    .div_wdata (DIV_W'(byte_merge(64'(div), bus.indata_i, bus.mask_i))),
    .div       (div),
    .tick      (tick)
  );

  // A software write to mtime wins over the tick and suppresses that increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (bus.wen_i && mtime_hit) begin
      mtime <= byte_merge(mtime, bus.indata_i, bus.mask_i);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_cmp
    assign time_hit[h] = (mtime >= mtimecmp[h]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip       <= '0;
      time_int_o <= '0;
      soft_int_o <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= MTIMECMP_RST;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (bus.wen_i && msip_hit[h] && msip_lane_en) msip[h] <= msip_lane_bit;
        if (bus.wen_i && cmp_hit[h])
          mtimecmp[h] <= byte_merge(mtimecmp[h], bus.indata_i, bus.mask_i);
      end
      time_int_o <= time_hit;
      soft_int_o <= msip;
    end
  end

  // Response stage: read data captured from pre-write state, writes return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.outdata_o <= '0;
      bus.valid_o   <= 1'b0;
    end else begin
      bus.outdata_o <= bus.ren_i ? rd_data_p0 : '0;
      bus.valid_o   <= bus.wen_i || bus.ren_i;
    end
  end

  always_comb begin
    cosim_mmio.store = bus.wen_i;
    cosim_mmio.addr  = bus.address_i;
    cosim_mmio.len   = ACCESS_LEN;
    cosim_mmio.val   = bus.wen_i ? bus.indata_i : rd_data_p0;
  end

  assign cosim_mtime = mtime;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer with two harts and hand-computed expectations.
module tb_clint_timer;
  import clint_pkg::*;

  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  time_int;
  logic [1:0]  soft_int;
  MMIOPack     cosim_mmio;
  logic [63:0] cosim_mtime;
  int          n_pass = 0;
  int          n_tot  = 0;

  clint_timer_if bus ();

  clint_timer #(
    .NUM_HARTS (2),
    .BASE_ADDR (BASE),
    .DIV_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .time_int_o  (time_int),
    .soft_int_o  (soft_int),
    .cosim_mmio  (cosim_mmio),
    .cosim_mtime (cosim_mtime)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 unit after the sampling edge.
  task automatic access(input logic w, input logic r, input logic [15:0] off,
                        input logic [63:0] data, input logic [7:0] m);
    bus.wen_i     = w;
    bus.ren_i     = r;
    bus.address_i = BASE + {48'b0, off};
    bus.indata_i  = data;
    bus.mask_i    = m;
    @(posedge clk); #1;
    bus.wen_i = 1'b0;
    bus.ren_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_tot++; if (bus.valid_o !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.valid_o); else n_pass++;
    n_tot++; if (bus.outdata_o !== 64'd0) $display("FAIL rst_outdata got %h exp 0", bus.outdata_o); else n_pass++;
    n_tot++; if (time_int !== 2'b00) $display("FAIL rst_time_int got %b exp 00", time_int); else n_pass++;
    n_tot++; if (soft_int !== 2'b00) $display("FAIL rst_soft_int got %b exp 00", soft_int); else n_pass++;
    n_tot++; if (cosim_mtime !== 64'd0) $display("FAIL rst_mtime got %h exp 0", cosim_mtime); else n_pass++;
  endtask

  task automatic test_idle_read();
    repeat (10) step();
    n_tot++; if (cosim_mtime !== 64'd10) $display("FAIL idle_mtime got %0d exp 10", cosim_mtime); else n_pass++;
    access(1'b0, 1'b1, MTIME_OFF, 64'd0, 8'h00);
    n_tot++; if (bus.valid_o !== 1'b1) $display("FAIL idle_valid got %b exp 1", bus.valid_o); else n_pass++;
    n_tot++; if (bus.outdata_o !== 64'd10) $display("FAIL idle_rdata got %0d exp 10", bus.outdata_o); else n_pass++;
    n_tot++; if (time_int !== 2'b00 || soft_int !== 2'b00)
      $display("FAIL idle_ints got %b/%b exp 00/00", time_int, soft_int); else n_pass++;
  endtask

  task automatic test_prescaler();
    logic [63:0] exp_mt;
    access(1'b1, 1'b0, DIV_OFF, 64'd3, 8'hFF);
    access(1'b1, 1'b0, MTIME_OFF, 64'd100, 8'hFF);
    n_tot++; if (cosim_mtime !== 64'd100) $display("FAIL div_k1 got %0d exp 100", cosim_mtime); else n_pass++;
    for (int k = 2; k <= 9; k++) begin
      step();
      exp_mt = 64'd100 + 64'(k / 4);
      n_tot++; if (cosim_mtime !== exp_mt)
        $display("FAIL div_k%0d got %0d exp %0d", k, cosim_mtime, exp_mt); else n_pass++;
    end
    access(1'b1, 1'b0, DIV_OFF, 64'd3, 8'hFF);
    for (int k = 11; k <= 14; k++) begin
      step();
      exp_mt = (k < 14) ? 64'd102 : 64'd103;
      n_tot++; if (cosim_mtime !== exp_mt)
        $display("FAIL div_restart_k%0d got %0d exp %0d", k, cosim_mtime, exp_mt); else n_pass++;
    end
    access(1'b1, 1'b1, DIV_OFF, 64'd0, 8'hFF);
    n_tot++; if (bus.outdata_o !== 64'd3) $display("FAIL div_read got %0d exp 3", bus.outdata_o); else n_pass++;
  endtask

  task automatic test_timer_int();
    logic [63:0] exp_mt;
    logic [1:0]  exp_ti;
    access(1'b1, 1'b0, MTIME_OFF, 64'd4, 8'hFF);
    access(1'b1, 1'b0, 16'h4008, 64'd20, 8'hFF);
    n_tot++; if (time_int !== 2'b00) $display("FAIL tint_start got %b exp 00", time_int); else n_pass++;
    for (int j = 1; j <= 17; j++) begin
      step();
      exp_mt = 64'd5 + 64'(j);
      exp_ti = (j >= 16) ? 2'b10 : 2'b00;
      n_tot++; if (cosim_mtime !== exp_mt || time_int !== exp_ti)
        $display("FAIL tint_j%0d got mtime %0d int %b exp %0d %b", j, cosim_mtime, time_int, exp_mt, exp_ti);
      else n_pass++;
    end
    access(1'b1, 1'b0, 16'h4008, ONES, 8'hFF);
    n_tot++; if (time_int !== 2'b10) $display("FAIL tint_hold got %b exp 10", time_int); else n_pass++;
    step();
    n_tot++; if (time_int !== 2'b00) $display("FAIL tint_clear got %b exp 00", time_int); else n_pass++;
  endtask

  task automatic test_wrap_partial();
    access(1'b1, 1'b0, MTIME_OFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    n_tot++; if (cosim_mtime !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL wrap_wr got %h exp fffffffffffffffe", cosim_mtime); else n_pass++;
    step();
    access(1'b0, 1'b1, MTIME_OFF, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== ONES) $display("FAIL wrap_max got %h exp %h", bus.outdata_o, ONES); else n_pass++;
    access(1'b0, 1'b1, MTIME_OFF, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== 64'd0) $display("FAIL wrap_zero got %h exp 0", bus.outdata_o); else n_pass++;
    access(1'b1, 1'b0, MTIME_OFF, 64'hAAAA_AAAA_0000_0010, 8'hFF);
    access(1'b1, 1'b0, MTIME_OFF, 64'hDEAD_BEEF_1234_5678, 8'h0F);
    n_tot++; if (cosim_mtime !== 64'hAAAA_AAAA_1234_5678)
      $display("FAIL partial_wr got %h exp aaaaaaaa12345678", cosim_mtime); else n_pass++;
    n_tot++; if (bus.valid_o !== 1'b1 || bus.outdata_o !== 64'd0)
      $display("FAIL partial_resp got %b/%h exp 1/0", bus.valid_o, bus.outdata_o); else n_pass++;
    step();
    n_tot++; if (cosim_mtime !== 64'hAAAA_AAAA_1234_5679)
      $display("FAIL partial_inc got %h exp aaaaaaaa12345679", cosim_mtime); else n_pass++;
  endtask

  task automatic test_msip();
    access(1'b1, 1'b0, 16'h0000, 64'd1, 8'hFF);
    n_tot++; if (soft_int !== 2'b00) $display("FAIL msip0_early got %b exp 00", soft_int); else n_pass++;
    step();
    n_tot++; if (soft_int !== 2'b01) $display("FAIL msip0_set got %b exp 01", soft_int); else n_pass++;
    access(1'b1, 1'b0, 16'h0004, 64'h0000_0001_0000_0000, 8'hF0);
    step();
    n_tot++; if (soft_int !== 2'b11) $display("FAIL msip1_set got %b exp 11", soft_int); else n_pass++;
    access(1'b0, 1'b1, 16'h0004, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== 64'h0000_0001_0000_0000)
      $display("FAIL msip1_read got %h exp 0000000100000000", bus.outdata_o); else n_pass++;
    access(1'b1, 1'b0, 16'h0000, 64'h0000_0000_FFFF_FFFE, 8'hFF);
    step();
    n_tot++; if (soft_int !== 2'b10) $display("FAIL msip0_clr got %b exp 10", soft_int); else n_pass++;
    access(1'b1, 1'b0, 16'h0004, 64'd0, 8'hF0);
    step();
    n_tot++; if (soft_int !== 2'b00) $display("FAIL msip1_clr got %b exp 00", soft_int); else n_pass++;
  endtask

  task automatic test_unmapped();
    access(1'b0, 1'b1, 16'h8000, 64'd0, 8'h00);
    n_tot++; if (bus.valid_o !== 1'b1 || bus.outdata_o !== 64'd0)
      $display("FAIL unmap_read got %b/%h exp 1/0", bus.valid_o, bus.outdata_o); else n_pass++;
    access(1'b1, 1'b0, 16'h0008, ONES, 8'hFF);
    n_tot++; if (bus.valid_o !== 1'b1) $display("FAIL unmap_wr_valid got %b exp 1", bus.valid_o); else n_pass++;
    step();
    n_tot++; if (soft_int !== 2'b00) $display("FAIL unmap_msip got %b exp 00", soft_int); else n_pass++;
    access(1'b1, 1'b0, 16'h4010, 64'd0, 8'hFF);
    access(1'b0, 1'b1, 16'h4000, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== ONES) $display("FAIL unmap_cmp0 got %h exp %h", bus.outdata_o, ONES); else n_pass++;
    access(1'b0, 1'b1, 16'h4008, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== ONES) $display("FAIL unmap_cmp1 got %h exp %h", bus.outdata_o, ONES); else n_pass++;
    n_tot++; if (time_int !== 2'b00) $display("FAIL unmap_tint got %b exp 00", time_int); else n_pass++;
  endtask

  task automatic test_rw_cosim();
    access(1'b1, 1'b1, 16'h4000, 64'h55, 8'hFF);
    n_tot++; if (bus.outdata_o !== ONES) $display("FAIL rw_prewrite got %h exp %h", bus.outdata_o, ONES); else n_pass++;
    access(1'b0, 1'b1, 16'h4000, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== 64'h55) $display("FAIL rw_postwrite got %h exp 55", bus.outdata_o); else n_pass++;
    access(1'b1, 1'b0, 16'h4000, ONES, 8'hFF);
    bus.ren_i = 1'b1; bus.address_i = BASE + 64'h4008; bus.indata_i = 64'h77; bus.mask_i = 8'h00;
    #1;
    n_tot++; if (cosim_mmio.store !== 1'b0 || cosim_mmio.addr !== BASE + 64'h4008 ||
                 cosim_mmio.len !== 4'd8 || cosim_mmio.val !== ONES)
      $display("FAIL cosim_rd got %b %h %0d %h", cosim_mmio.store, cosim_mmio.addr, cosim_mmio.len, cosim_mmio.val);
    else n_pass++;
    bus.ren_i = 1'b0; bus.wen_i = 1'b1; bus.address_i = BASE + 64'h8000; bus.indata_i = 64'h1234;
    #1;
    n_tot++; if (cosim_mmio.store !== 1'b1 || cosim_mmio.addr !== BASE + 64'h8000 || cosim_mmio.val !== 64'h1234)
      $display("FAIL cosim_wr got %b %h %h exp 1 %h 1234", cosim_mmio.store, cosim_mmio.addr, cosim_mmio.val, BASE + 64'h8000);
    else n_pass++;
    @(posedge clk); #1;
    bus.wen_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    access(1'b1, 1'b0, DIV_OFF, 64'd5, 8'hFF);
    access(1'b1, 1'b0, 16'h0000, 64'd1, 8'hFF);
    access(1'b1, 1'b0, 16'h4000, 64'd0, 8'hFF);
    step();
    n_tot++; if (time_int !== 2'b01 || soft_int !== 2'b01)
      $display("FAIL prerst_ints got %b/%b exp 01/01", time_int, soft_int); else n_pass++;
    bus.ren_i = 1'b1; bus.address_i = BASE + {48'b0, MTIME_OFF};
    #2; rst = 1'b1;
    @(posedge clk); #1;
    bus.ren_i = 1'b0;
    n_tot++; if (bus.valid_o !== 1'b0 || bus.outdata_o !== 64'd0)
      $display("FAIL midrst_resp got %b/%h exp 0/0", bus.valid_o, bus.outdata_o); else n_pass++;
    n_tot++; if (time_int !== 2'b00 || soft_int !== 2'b00 || cosim_mtime !== 64'd0)
      $display("FAIL midrst_state got %b/%b/%h exp 00/00/0", time_int, soft_int, cosim_mtime); else n_pass++;
    rst = 1'b0;
    access(1'b0, 1'b1, MTIME_OFF, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== 64'd0) $display("FAIL postrst_mtime got %h exp 0", bus.outdata_o); else n_pass++;
    access(1'b0, 1'b1, DIV_OFF, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== 64'd0) $display("FAIL postrst_div got %h exp 0", bus.outdata_o); else n_pass++;
    access(1'b0, 1'b1, 16'h4000, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== ONES) $display("FAIL postrst_cmp got %h exp %h", bus.outdata_o, ONES); else n_pass++;
    access(1'b0, 1'b1, 16'h0000, 64'd0, 8'h00);
    n_tot++; if (bus.outdata_o !== 64'd0 || bus.valid_o !== 1'b1)
      $display("FAIL postrst_msip got %h/%b exp 0/1", bus.outdata_o, bus.valid_o); else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.wen_i     = 1'b0;
    bus.ren_i     = 1'b0;
    bus.address_i = '0;
    bus.indata_i  = '0;
    bus.mask_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_idle_read();
    test_prescaler();
    test_timer_int();
    test_wrap_partial();
    test_msip();
    test_unmapped();
    test_rw_cosim();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
# clint_timer

Parametrised machine-timer and software-interrupt unit for multi-hart configurations, the successor to the single-hart MMIO timer. Holds one free-running 64-bit `mtime` with a programmable prescaler, one `mtimecmp` and one `msip` bit per hart, and raises registered per-hart timer and software interrupts. Sits on the data-side MMIO port beside the other memory-mapped peripherals and feeds the interrupt inputs of each hart's CSR unit.

## Interface

Parameters:
- `NUM_HARTS`, 2: number of hart contexts (1..16).
- `BASE_ADDR`, 64'h0200_0000: region base; all offsets below are relative to it.
- `DIV_W`, 16: width of the prescaler divide register.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `address_i`  in  64  byte address of the access.
- `indata_i`  in  64  write data, lane-aligned to the address.
- `wen_i`  in  1  write strobe, one cycle per access.
- `ren_i`  in  1  read strobe, one cycle per access.
- `mask_i`  in  8  byte enables for writes.
- `outdata_o`  out  64  read data, valid while `valid_o` is high.
- `valid_o`  out  1  read/write completion, one cycle after the strobe.
- `time_int_o`  out  NUM_HARTS  per-hart machine timer interrupt.
- `soft_int_o`  out  NUM_HARTS  per-hart machine software interrupt.
- `cosim_mmio`  out  MMIOPack  access record for co-simulation.
- `cosim_mtime`  out  64  current `mtime`.

## Operation

- Map (offsets):
  - `MSIP[h]` at 0x0000 + 4h: bit 0 only, 32-bit.
  - `MTIMECMP[h]` at 0x4000 + 8h: 64-bit.
  - `DIV` at 0xBFF0: DIV_W bits, zero-extended on read.
  - `MTIME` at 0xBFF8: 64-bit.
- Writes merge byte lanes selected by `mask_i`. For 32-bit registers, lanes beyond the register width are ignored. Writes to unmapped offsets or harts `h >= NUM_HARTS` are dropped.
- Reads of unmapped offsets return 0. `valid_o` still pulses.
- Prescaler:
  - Counter `pcnt` counts 0..DIV; a tick fires when `pcnt == DIV`, then `pcnt` returns to 0.
  - With DIV = 0, `mtime` increments every cycle.
  - A write to `DIV` clears `pcnt` in the same cycle.
- `mtime` increments by 1 per tick and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- A write to `MTIME` in a tick cycle takes priority. The new value is the merge of `indata_i` with the pre-increment `mtime`, and there is no increment that cycle.
- `time_int_o[h]` is registered: `mtime >= mtimecmp[h]` (unsigned), evaluated on the current register values.
- `soft_int_o[h]` is registered from `msip[h]`.
- Simultaneous `wen_i` and `ren_i` perform the write; the read returns the pre-write value.

## Timing

- Reset values:
  - `mtime` = 0, `pcnt` = 0, `DIV` = 0.
  - All `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt fires out of reset.
  - `msip` = 0.
  - `outdata_o` = 0, `valid_o` = 0, `time_int_o` = 0, `soft_int_o` = 0.
- Accesses:
  - A strobe in cycle N gives `valid_o` = 1 in cycle N+1; `outdata_o` holds the value captured in N, and 0 for writes.
  - No back-pressure: a new strobe may arrive every cycle.
- Interrupt latency:
  - `mtimecmp`/`mtime`/`msip` write in N, register updates at end of N, interrupt outputs change at end of N+1.
  - A tick making `mtime == mtimecmp` at end of N raises `time_int_o` at end of N+1.
- `time_int_o` deasserts the cycle after `mtimecmp` is raised above `mtime`; it is level, not sticky.
- Reset asserted mid-access: all state returns to reset values immediately, and the pending `valid_o` is dropped.
- `cosim_mmio` is combinational on the request:
  - `store` = `wen_i`, `addr` = `address_i`, `len` = 8.
  - `val` = write data for writes, or the pre-access value for reads.

## Structure

- Package `clint_pkg`: offset constants (`MSIP_OFF`, `MTIMECMP_OFF`, `DIV_OFF`, `MTIME_OFF`), the `mtimecmp` reset constant, and a byte-merge function (old, new, mask).
- Sub-module `clint_prescaler`: `DIV` register, `pcnt`, `tick` output; DIV_W parametrised.
- Top level: address decode, per-hart register arrays generated over NUM_HARTS, comparators, output registers.

## Test plan

- Reset, DIV = 0, 10 idle cycles, then read MTIME: read issued with `mtime` = 10 returns 10 one cycle later with `valid_o` = 1; all interrupts remain 0.
- Write DIV = 3, then observe `cosim_mtime`: increments exactly once every 4 cycles; rewriting DIV mid-count restarts the period.
- Write MTIMECMP[1] = 20 with `mtime` = 5, DIV = 0: `time_int_o[1]` rises 1 cycle after `mtime` reaches 20, `time_int_o[0]` stays 0. Then write MTIMECMP[1] = 0xFFFF…: `time_int_o[1]` clears the cycle after the write completes.
- Write MTIME = 0xFFFF_FFFF_FFFF_FFFE, mask 0xFF: reads 0xFFFF_FFFF_FFFF_FFFF, then 0, showing wrap. Partial write with mask 0x0F, data 0x1234_5678, over `mtime` = 0xAAAA_AAAA_0000_0010: result 0xAAAA_AAAA_1234_5678, with no increment in the write cycle.
- Write MSIP[0] = 1: `soft_int_o` = 2'b01 two cycles later. Write MSIP[0] = 0xFFFF_FFFE: clears it.
- Unmapped read at offset 0x8000, and write to MSIP[NUM_HARTS]: read returns 0 with `valid_o` = 1; no state changes. Assert `rst` mid-read: `valid_o` stays 0 and all registers return to their reset values.
